// File: rtl/game_pkg.sv
// game_pkg: shared state encoding, clear clamp and drop-period helper for the game controller
package game_pkg;
  typedef enum logic [1:0] {HOME = 2'b00, PLAY = 2'b01, OVER = 2'b10, PAUSE = 2'b11} game_state_t;
  localparam int MAX_LINES_PER_CLEAR = 4;
  function automatic logic [31:0] calc_period(input logic [31:0] base, input logic [31:0] step,
                                              input logic [31:0] min_p, input logic [31:0] lvl);
    logic [31:0] cut;
    cut = lvl * step;
    return (cut >= base || base - cut < min_p) ? min_p : base - cut;
  endfunction
endpackage

// File: rtl/game_ctrl_fsm_drop_timer.sv
// drop_timer: gravity counter; the >= compare lets a shortened period fire at once instead of wrapping
module drop_timer #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_period,
  output logic         o_tick
);
  logic [W-1:0] r_cnt;
  logic         r_tick;
  logic         w_fire;
  assign w_fire = r_cnt >= i_period - W'(1);
  always_ff @(posedge clk)
    if (!reset_n || i_clr) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= i_en && w_fire;
      r_cnt  <= !i_en ? r_cnt : w_fire ? '0 : r_cnt + W'(1);
    end
  assign o_tick = r_tick;
endmodule

// File: rtl/game_ctrl_fsm.sv
// game_ctrl_fsm: home/play/pause/over sequencer with line/level bookkeeping and level-scaled gravity
module game_ctrl_fsm import game_pkg::*; #(
  parameter int MAX_LEVEL       = 9,
  parameter int LINES_PER_LEVEL = 10,
  parameter int BASE_PERIOD     = 50_000_000,
  parameter int PERIOD_STEP     = 4_000_000,
  parameter int MIN_PERIOD      = 5_000_000,
  parameter int OVER_HOLD       = 100_000_000,
  parameter int LINE_W          = 12
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           i_start,
  input  logic                           i_pause,
  input  logic                           i_game_over,
  input  logic [2:0]                     i_lines_cleared,
  output logic [1:0]                     o_state,
  output logic                           o_play_en,
  output logic                           o_drop_tick,
  output logic [$clog2(MAX_LEVEL+1)-1:0] o_level,
  output logic [LINE_W-1:0]              o_lines_total
);
  localparam int LW = $clog2(MAX_LEVEL + 1);
  localparam int IW = $clog2(LINES_PER_LEVEL + MAX_LINES_PER_CLEAR);
  localparam int HW = $clog2(OVER_HOLD);
  localparam logic [LW-1:0] LVL_MAX = LW'(MAX_LEVEL);
  localparam logic [IW-1:0] LPL = IW'(LINES_PER_LEVEL);
  localparam logic [HW-1:0] HOLD_LAST = HW'(OVER_HOLD - 1);
  localparam logic [2:0] CLR_MAX = 3'(MAX_LINES_PER_CLEAR);
  game_state_t       r_state;
  logic              r_play_en, r_start_q, r_pause_q;
  logic [LW-1:0]     r_level;
  logic [LINE_W-1:0] r_lines_total;
  logic [IW-1:0]     r_in_lvl;
  logic [HW-1:0]     r_hold;
  logic              w_start_rise, w_pause_rise, w_clr, w_en;
  logic [2:0]        w_lines;
  logic [LINE_W:0]   w_lt_sum;
  logic [IW-1:0]     w_in_sum;
  logic [31:0]       w_period;
  assign w_start_rise = i_start & ~r_start_q;
  assign w_pause_rise = i_pause & ~r_pause_q;
  assign w_lines      = i_lines_cleared > CLR_MAX ? CLR_MAX : i_lines_cleared;
  assign w_lt_sum     = {1'b0, r_lines_total} + (LINE_W+1)'(w_lines);
  assign w_in_sum     = r_in_lvl + IW'(w_lines);
  assign w_period     = calc_period(BASE_PERIOD, PERIOD_STEP, MIN_PERIOD, 32'(r_level));
  assign w_clr        = r_state == HOME && w_start_rise;
  // Freeze the timer on the exit edge so no tick leaks into PAUSE/OVER
  assign w_en         = r_state == PLAY && !i_game_over && !w_pause_rise;
  always_ff @(posedge clk)
    if (!reset_n) begin
      r_state       <= HOME;
      r_play_en     <= 1'b0;
      r_start_q     <= 1'b1;
      r_pause_q     <= 1'b1;
      r_level       <= '0;
      r_lines_total <= '0;
      r_in_lvl      <= '0;
      r_hold        <= '0;
    end else begin
      r_start_q <= i_start;
      r_pause_q <= i_pause;
      case (r_state)
        HOME: if (w_start_rise) begin
          r_state       <= PLAY;
          r_play_en     <= 1'b1;
          r_level       <= '0;
          r_lines_total <= '0;
          r_in_lvl      <= '0;
        end
        PLAY: begin
          r_lines_total <= w_lt_sum[LINE_W] ? '1 : w_lt_sum[LINE_W-1:0];
          r_in_lvl      <= w_in_sum >= LPL ? w_in_sum - LPL : w_in_sum;
          if (w_in_sum >= LPL && r_level != LVL_MAX) r_level <= r_level + LW'(1);
          r_state   <= i_game_over ? OVER : w_pause_rise ? PAUSE : PLAY;
          r_play_en <= !i_game_over && !w_pause_rise;
          r_hold    <= '0;
        end
        PAUSE: if (w_pause_rise) begin
          r_state   <= PLAY;
          r_play_en <= 1'b1;
        end
        OVER: begin
          r_hold  <= r_hold == HOLD_LAST ? r_hold : r_hold + HW'(1);
          r_state <= r_hold == HOLD_LAST && w_start_rise ? HOME : OVER;
        end
        default: begin
          r_state   <= HOME;
          r_play_en <= 1'b0;
        end
      endcase
    end
  drop_timer #(.W(32)) u_drop (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_clr    (w_clr),
    .i_en     (w_en),
    .i_period (w_period),
    .o_tick   (o_drop_tick)
  );
  assign o_state       = r_state;
  assign o_play_en     = r_play_en;
  assign o_level       = r_level;
  assign o_lines_total = r_lines_total;
endmodule

// File: tb/tb_game_ctrl_fsm.sv
// tb_game_ctrl_fsm: scoreboard bench; expectations are queued with each stimulus cycle and drained after the edge
module tb_game_ctrl_fsm;
  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] val;
  } exp_t;
  logic        clk = 1'b0;
  logic        reset_n, start, pause, game_over;
  logic [2:0]  lines;
  logic [1:0]  state, level;
  logic        play_en, drop_tick;
  logic [11:0] lines_total;
  exp_t        sb[$];
  int          n_chk = 0;
  int          n_pass = 0;
  always #5 clk = ~clk;
  game_ctrl_fsm #(
    .MAX_LEVEL(3), .LINES_PER_LEVEL(4), .BASE_PERIOD(8), .PERIOD_STEP(2),
    .MIN_PERIOD(3), .OVER_HOLD(5), .LINE_W(12)
  ) dut (
    .clk(clk), .reset_n(reset_n), .i_start(start), .i_pause(pause), .i_game_over(game_over),
    .i_lines_cleared(lines), .o_state(state), .o_play_en(play_en), .o_drop_tick(drop_tick),
    .o_level(level), .o_lines_total(lines_total)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    else n_pass++;
  endtask
  function automatic logic [31:0] obs(input int sel);
    return sel == 0 ? 32'(state) : sel == 1 ? 32'(play_en) : sel == 2 ? 32'(drop_tick) :
           sel == 3 ? 32'(level) : 32'(lines_total);
  endfunction
  task automatic want(input string tag, input int sel, input logic [31:0] val);
    sb.push_back('{tag, sel, val});
  endtask
  task automatic want_all(input string tag, input int st, input int pe, input int tk, input int lv, input int lt);
    want({tag, "_state"}, 0, st);
    want({tag, "_play_en"}, 1, pe);
    want({tag, "_tick"}, 2, tk);
    want({tag, "_level"}, 3, lv);
    want({tag, "_lines"}, 4, lt);
  endtask
  task automatic step(input logic st, input logic pa, input logic go, input logic [2:0] ln);
    exp_t e;
    start = st; pause = pa; game_over = go; lines = ln;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, obs(e.sel), e.val);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int found;
    reset_n = 1'b0;
    step(1, 0, 0, 0);
    want_all("rst", 0, 0, 0, 0, 0);
    step(1, 0, 0, 0);
    reset_n = 1'b1;
    want("held_start", 0, 0);
    step(1, 0, 0, 0);
    want("start_low", 0, 0);
    step(0, 0, 0, 0);
    want_all("start", 1, 1, 0, 0, 0);
    step(1, 0, 0, 0);
    for (int k = 1; k <= 16; k++) begin
      want($sformatf("tick8_%0d", k), 2, (k % 8 == 0) ? 1 : 0);
      step(0, 0, 0, 0);
    end
    for (int k = 0; k < 3; k++) step(0, 0, 0, 0);
    want("pause_state", 0, 3);
    want("pause_play_en", 1, 0);
    want("pause_tick", 2, 0);
    step(0, 1, 0, 0);
    for (int k = 0; k < 20; k++) begin
      want("paused_state", 0, 3);
      want("paused_tick", 2, 0);
      step(0, 0, 0, 0);
    end
    want("resume_state", 0, 1);
    want("resume_tick", 2, 0);
    step(0, 1, 0, 0);
    for (int k = 1; k <= 5; k++) begin
      want($sformatf("resume_tick_%0d", k), 2, (k == 5) ? 1 : 0);
      step(0, 0, 0, 0);
    end
    want("l3_lines", 4, 3);
    want("l3_level", 3, 0);
    step(0, 0, 0, 3);
    want("l5_lines", 4, 5);
    want("l5_level", 3, 1);
    step(0, 0, 0, 2);
    for (int k = 3; k <= 12; k++) begin
      want($sformatf("tick6_%0d", k), 2, (k == 6 || k == 12) ? 1 : 0);
      step(0, 0, 0, 0);
    end
    want("clamp7_lines", 4, 9);
    want("clamp7_level", 3, 2);
    step(0, 0, 0, 7);
    for (int k = 0; k < 9; k++) step(0, 0, 0, 4);
    want("sat_level", 3, 3);
    want("sat_lines", 4, 49);
    step(0, 0, 0, 4);
    found = 0;
    for (int k = 0; k < 10 && found == 0; k++) begin
      step(0, 0, 0, 0);
      found = drop_tick ? 1 : 0;
    end
    chk("tick3_seen", found, 1);
    for (int k = 1; k <= 6; k++) begin
      want($sformatf("tick3_%0d", k), 2, (k % 3 == 0) ? 1 : 0);
      step(0, 0, 0, 0);
    end
    want_all("over", 2, 0, 0, 3, 49);
    step(0, 1, 1, 0);
    for (int k = 1; k <= 5; k++) begin
      want($sformatf("over_hold_%0d", k), 0, 2);
      step(k % 2 == 0, 0, 0, 0);
    end
    want_all("home", 0, 0, 0, 3, 49);
    step(1, 0, 0, 0);
    want("home_keep_level", 3, 3);
    want("home_keep_lines", 4, 49);
    step(0, 0, 0, 0);
    want_all("restart", 1, 1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 4);
    want("pre_rst_level", 3, 2);
    want("pre_rst_lines", 4, 8);
    step(0, 0, 0, 4);
    reset_n = 1'b0;
    want_all("midrst", 0, 0, 0, 0, 0);
    step(0, 0, 0, 0);
    reset_n = 1'b1;
    want("post_rst_state", 0, 0);
    step(0, 0, 0, 0);
    want("game3_state", 0, 1);
    step(1, 0, 0, 0);
    for (int k = 0; k < 1029; k++) step(0, 0, 0, 4);
    want("linesat_lines", 4, 4095);
    want("linesat_level", 3, 3);
    step(0, 0, 0, 4);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
